edge_event_arbiter: RTL and testbench

Watches NCH level inputs, detects a rising edge on each channel, and keeps one pending event per channel. It shares a single event-output port among all channels using round-robin arbitration and a valid/ready handshake. It sits between the per-signal level sources (already synchronised to clk upstream) and the single event consumer, for example an interrupt or command sequencer.

---
 rtl/edge_evt_pkg.sv | 38 +++
 rtl/edge_event_arbiter_if.sv | 27 ++
 rtl/edge_evt_chan.sv | 57 +++++
 rtl/edge_event_arbiter.sv | 98 +++++++++
 tb/tb_edge_event_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/edge_evt_pkg.sv
// Shared types and the round-robin search used by edge_event_arbiter.
// Build option: BOTH_EDGES_EN (queue falling edges as well as rising edges).
package edge_evt_pkg;

    localparam int MAX_CH   = 16;
    localparam int MAX_ID_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    // First set bit of pend at or above ptr, wrapping at nch back to 0.
    function automatic pick_t rr_pick(input logic [MAX_CH-1:0]   pend,
                                      input logic [MAX_ID_W-1:0] ptr,
                                      input int unsigned         nch);
        pick_t       r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < MAX_CH; k++) begin
            if (k < nch && !r.found) begin
                j = 32'(ptr) + k;
                if (j >= nch) j = j - nch;
                if (pend[j[MAX_ID_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[MAX_ID_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Level inputs, event handshake and status bundle of edge_event_arbiter.
// The master side is the arbiter; the slave side is the source/consumer.
interface edge_event_arbiter_if #(parameter int NCH = 4);

    localparam int ID_W = $clog2(NCH);

    logic            en;
    logic [NCH-1:0]  level;
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic            evt_rise;
    logic [NCH-1:0]  pending;
    logic [NCH-1:0]  overflow;
    logic            ovf_clr;

    modport master (
        input  en, level, evt_ready, ovf_clr,
        output evt_valid, evt_id, evt_rise, pending, overflow
    );

    modport slave (
        output en, level, evt_ready, ovf_clr,
        input  evt_valid, evt_id, evt_rise, pending, overflow
    );

endinterface

// File: rtl/edge_evt_chan.sv
// One channel: edge detect, pending/type/overflow bits and their priority logic.
// Build option: BOTH_EDGES_EN adds fall detection and the stored edge type.
module edge_evt_chan (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic level,
    input  logic hs,
    input  logic ovf_clr,
    output logic pending,
    output logic ptype,
    output logic overflow
);

    logic prev_level;
    logic rise;
    logic edge_any;
    logic set_ev;

    assign rise = level & ~prev_level;

`ifdef BOTH_EDGES_EN
    logic fall;
    assign fall     = ~level & prev_level;
    assign edge_any = rise | fall;
`else
    assign edge_any = rise;
`endif

    assign set_ev = edge_any & en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_level <= 1'b0;
            pending    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            prev_level <= level;
            // A new edge beats the handshake clear so it is never lost.
            if (set_ev)  pending <= 1'b1;
            else if (hs) pending <= 1'b0;
            if (set_ev && pending && !hs) overflow <= 1'b1;
            else if (ovf_clr)             overflow <= 1'b0;
        end
    end

`ifdef BOTH_EDGES_EN
    // Type only follows an accepted edge; a dropped edge keeps the old type.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           ptype <= 1'b1;
        else if (set_ev && (!pending || hs)) ptype <= rise;
    end
`else
    assign ptype = 1'b1;
`endif

endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge event queue per channel, round-robin onto one valid/ready port.
// Build option: BOTH_EDGES_EN also queues falling edges and reports their type.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int NCH = 4
) (
    input logic                 clk,
    input logic                 rst,
    edge_event_arbiter_if.master bus
);

    localparam int ID_W = $clog2(NCH);
    localparam logic [0:0] S_IDLE  = 1'(IDLE);
    localparam logic [0:0] S_OFFER = 1'(OFFER);

    logic [0:0]          state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     evt_id_q;
    logic                evt_valid_q;
    logic                evt_rise_q;
    logic                handshake;
    logic [NCH-1:0]      hs_vec;
    logic [NCH-1:0]      pend_vec;
    logic [NCH-1:0]      type_vec;
    logic [NCH-1:0]      ovf_vec;
    logic [MAX_CH-1:0]   pend_ext;
    logic [MAX_ID_W-1:0] ptr_ext;
    pick_t               pick;
    logic                unused_pick;

    assign handshake = evt_valid_q & bus.evt_ready;

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_chan
            assign hs_vec[g] = handshake & (evt_id_q == ID_W'(g));
            edge_evt_chan u_chan (
                .clk      (clk),
                .rst      (rst),
                .en       (bus.en),
                .level    (bus.level[g]),
                .hs       (hs_vec[g]),
                .ovf_clr  (bus.ovf_clr),
                .pending  (pend_vec[g]),
                .ptype    (type_vec[g]),
                .overflow (ovf_vec[g])
            );
        end
    endgenerate

    always_comb begin
        pend_ext           = '0;
        pend_ext[NCH-1:0]  = pend_vec;
        ptr_ext            = '0;
        ptr_ext[ID_W-1:0]  = rr_ptr;
    end

    assign pick        = rr_pick(pend_ext, ptr_ext, NCH);
    assign unused_pick = ^pick.idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            evt_id_q    <= '0;
            evt_valid_q <= 1'b0;
            evt_rise_q  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick.found) begin
                        evt_id_q    <= pick.idx[ID_W-1:0];
                        evt_rise_q  <= type_vec[pick.idx[ID_W-1:0]];
                        evt_valid_q <= 1'b1;
                        state       <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    // Id and type stay frozen until the consumer takes them.
                    if (handshake) begin
                        evt_valid_q <= 1'b0;
                        rr_ptr      <= (evt_id_q == ID_W'(NCH-1)) ? '0 : evt_id_q + ID_W'(1);
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_id    = evt_id_q;
    assign bus.evt_rise  = evt_rise_q;
    assign bus.pending   = pend_vec;
    assign bus.overflow  = ovf_vec;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (NCH=4) with immediate-assertion checks.
module tb_edge_event_arbiter;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   evq[$];
    int   riseq[$];

    edge_event_arbiter_if #(.NCH(4)) bus ();

    edge_event_arbiter #(.NCH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted event as seen by the consumer.
    always @(posedge clk) begin
        if (!rst && bus.evt_valid && bus.evt_ready) begin
            evq.push_back(int'(bus.evt_id));
            riseq.push_back(int'(bus.evt_rise));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.level     = '0;
        bus.en        = 1'b1;
        bus.evt_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        evq.delete();
        riseq.delete();
    endtask

    initial begin
        n_chk         = 0;
        n_fail        = 0;
        rst           = 1'b0;
        bus.level     = '0;
        bus.en        = 1'b1;
        bus.evt_ready = 1'b0;
        bus.ovf_clr   = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst valid", bus.evt_valid, 0);
        chk("rst pending", bus.pending, 0);
        chk("rst overflow", bus.overflow, 0);
        chk("rst id", bus.evt_id, 0);
        chk("rst rise", bus.evt_rise, 1);
        do_reset();

        // single pulse on channel 2
        bus.level = 4'b0100;
        tick();
        chk("t1 pending", bus.pending, 4'b0100);
        chk("t1 valid early", bus.evt_valid, 0);
        tick();
        chk("t1 valid", bus.evt_valid, 1);
        chk("t1 id", bus.evt_id, 2);
        tick();
        chk("t1 hold id", bus.evt_id, 2);
        bus.level     = 4'b0000;
        bus.evt_ready = 1'b1;
        tick();
        chk("t1 valid done", bus.evt_valid, 0);
        chk("t1 pending done", bus.pending, 0);
        bus.evt_ready = 1'b0;
        tick();
        chk("t1 nevt", evq.size(), 1);
        chk("t1 evt id", evq[0], 2);

        // simultaneous rises 0,1,3 with ready tied high
        do_reset();
        bus.level     = 4'b1011;
        bus.evt_ready = 1'b1;
        tick();
        chk("t2 pending", bus.pending, 4'b1011);
        chk("t2 valid A", bus.evt_valid, 0);
        tick(); chk("t2 id0", bus.evt_id, 0); chk("t2 v0", bus.evt_valid, 1);
        tick(); chk("t2 bubble0", bus.evt_valid, 0); chk("t2 pend1", bus.pending, 4'b1010);
        tick(); chk("t2 id1", bus.evt_id, 1); chk("t2 v1", bus.evt_valid, 1);
        tick(); chk("t2 bubble1", bus.evt_valid, 0);
        tick(); chk("t2 id3", bus.evt_id, 3); chk("t2 v3", bus.evt_valid, 1);
        tick(); chk("t2 pend end", bus.pending, 0);
        chk("t2 nevt", evq.size(), 3);
        chk("t2 order", {evq[0][7:0], evq[1][7:0], evq[2][7:0]}, 24'h000103);
        // pointer must now be back at 0: with 0 and 3 pending, 0 wins
        bus.level = 4'b0000;
        tick();
        evq.delete();
        bus.level = 4'b1001;
        tick(); chk("t2 pend 1001", bus.pending, 4'b1001);
        tick(); chk("t2 ptr0 id", bus.evt_id, 0);
        tick();
        tick(); chk("t2 then id3", bus.evt_id, 3);
        tick();
        chk("t2b nevt", evq.size(), 2);

        // overflow on channel 1 with consumer stalled
        evq.delete();
        bus.evt_ready = 1'b0;
        bus.level     = 4'b0010;
        tick(); chk("t3 pending", bus.pending, 4'b0010);
        tick(); chk("t3 id1", bus.evt_id, 1);
        bus.level = 4'b0000;
        tick();
        chk("t3 no ovf yet", bus.overflow, 0);
        bus.level = 4'b0010;
        tick();
        chk("t3 overflow", bus.overflow, 4'b0010);
        chk("t3 pend still", bus.pending, 4'b0010);
        repeat (6) tick();
        chk("t3 still offering", bus.evt_valid, 1);
        bus.evt_ready = 1'b1;
        tick();
        chk("t3 pend cleared", bus.pending, 0);
        chk("t3 ovf sticky", bus.overflow, 4'b0010);
        bus.evt_ready = 1'b0;
        bus.ovf_clr   = 1'b1;
        tick();
        chk("t3 ovf clr", bus.overflow, 0);
        bus.ovf_clr = 1'b0;
        chk("t3 nevt", evq.size(), 1);
        chk("t3 evt id", evq[0], 1);
        bus.level = 4'b0000;
        tick();

        // channel 0 re-rises on its own handshake
        do_reset();
        bus.level = 4'b0001;
        tick();
        tick(); chk("t4 id0", bus.evt_id, 0);
        bus.level = 4'b0000;
        tick();
        bus.level     = 4'b1111;
        bus.evt_ready = 1'b1;
        tick();
        chk("t4 pending", bus.pending, 4'b1111);
        chk("t4 no ovf", bus.overflow, 0);
        tick(); chk("t4 next id1", bus.evt_id, 1);
        repeat (7) tick();
        chk("t4 pend end", bus.pending, 0);
        chk("t4 nevt", evq.size(), 5);
        chk("t4 order", {evq[0][3:0], evq[1][3:0], evq[2][3:0], evq[3][3:0], evq[4][3:0]}, 20'h01230);
        bus.evt_ready = 1'b0;
        bus.level     = 4'b0000;
        tick();

        // en=0 blocks new rises but not the in-flight offer
        evq.delete();
        bus.level = 4'b1000;
        tick();
        tick(); chk("t5 id3", bus.evt_id, 3);
        bus.en    = 1'b0;
        bus.level = 4'b1100;
        tick();
        chk("t5 pend masked", bus.pending, 4'b1000);
        chk("t5 offer kept", bus.evt_valid, 1);
        bus.evt_ready = 1'b1;
        tick();
        chk("t5 hs pend", bus.pending, 0);
        tick(); tick();
        chk("t5 no ev2", bus.evt_valid, 0);
        bus.en = 1'b1;
        tick(); tick();
        chk("t5 no edge", bus.pending, 0);
        chk("t5 nevt", evq.size(), 1);
        bus.evt_ready = 1'b0;

`ifdef BOTH_EDGES_EN
        // rise then fall on channel 0, each drained
        do_reset();
        bus.level = 4'b0001;
        tick();
        tick(); chk("b rise id", bus.evt_id, 0); chk("b rise t", bus.evt_rise, 1);
        bus.evt_ready = 1'b1;
        tick();
        bus.evt_ready = 1'b0;
        bus.level     = 4'b0000;
        tick(); chk("b fall pend", bus.pending, 4'b0001);
        tick(); chk("b fall id", bus.evt_id, 0); chk("b fall t", bus.evt_rise, 0);
        bus.evt_ready = 1'b1;
        tick();
        bus.evt_ready = 1'b0;
        chk("b nevt", evq.size(), 2);
        chk("b types", {riseq[0][0], riseq[1][0]}, 2'b10);
`else
        // falling edges are ignored
        bus.level = 4'b0000;
        tick(); tick();
        chk("t5 fall ignored", bus.pending, 0);
        chk("t5 fall no valid", bus.evt_valid, 0);
`endif

        // async reset in the middle of an offer
        bus.level = 4'b0001;
        tick();
        tick(); chk("t6 offer", bus.evt_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6 async valid", bus.evt_valid, 0);
        chk("t6 async pend", bus.pending, 0);
        bus.level = 4'b0000;
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("t6 quiet", bus.evt_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
